seq_det_param: RTL and testbench
================================

# seq_det_param

Parametrised serial pattern detector and the successor to the fixed 4-state "1010" detector. It matches a runtime-programmable bit pattern of 1 to MAX_LEN bits against a qualified serial input stream. Overlapping or non-overlapping matching is selectable at runtime. The match output is a registered one-cycle pulse, and a saturating match counter is provided. It sits in the FSM library as the general-purpose detector for serial-stream framing and protocol checks.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..32)
- CNT_W, 8, match counter width (1..32)
- LEN_W, $clog2(MAX_LEN+1), derived; width of pat_len

- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high; clears all state
- x  in  1  serial data bit
- in_valid  in  1  x is sampled only when high
- cfg_load  in  1  one-cycle strobe; latches pattern, pat_len, overlap
- pattern  in  MAX_LEN  bit pat_len-1 = first bit expected, bit 0 = last bit expected; bits ≥ pat_len ignored
- pat_len  in  LEN_W  pattern length; legal range 1..MAX_LEN
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- clr_count  in  1  clears match_count and count_sat
- match  out  1  one-cycle pulse, asserted the cycle after the completing bit is sampled
- match_count  out  CNT_W  number of matches, saturating
- count_sat  out  1  sticky; match_count reached all-ones
- armed  out  1  legal configuration loaded; detector running
- cfg_err  out  1  sticky; last cfg_load had an illegal pat_len

## Operation
- States: IDLE and RUN.
- Reset state is IDLE. After reset all outputs are 0 and the internal history, fill count, and latched config are all 0.
- IDLE:
  - in_valid is ignored.
  - On cfg_load with 1 ≤ pat_len ≤ MAX_LEN: latch the config, clear history and fill, clear cfg_err, go to RUN.
  - On cfg_load with an illegal pat_len: set cfg_err and stay in IDLE.
- RUN (armed=1):
  - On each in_valid cycle: hist <= {hist[MAX_LEN-2:0], x} and fill <= min(fill+1, MAX_LEN).
  - A hit occurs when fill_next ≥ len and hist_next[len-1:0] == pat[len-1:0].
  - On a hit, match is driven to 1 on the next cycle.
  - Non-overlap mode: on a hit, fill <= 0, so the next match needs len fresh bits.
  - Overlap mode: fill is unaffected by a hit.
- cfg_load in RUN with a legal pat_len: reload the config, clear history and fill, stay in RUN. Any bit presented that cycle is discarded and no match is produced.
- cfg_load in RUN with an illegal pat_len: set cfg_err and return to IDLE.
- match_count:
  - Increments by 1 on each hit, saturating at 2^CNT_W-1.
  - count_sat is set in the cycle the count reaches all-ones.
- clr_count:
  - Resets match_count to 0 and clears count_sat.
  - If a hit occurs in the same cycle, the clear takes priority and the hit is still counted, giving match_count = 1.
- Length-1 patterns: every valid bit equal to pat[0] is a hit, in both modes.
- The pattern register is sampled only at cfg_load. Later changes on the pattern, pat_len, and overlap inputs have no effect.

## Timing
- Latency: the completing bit is sampled at edge N. match=1 and the new match_count are both visible after edge N and hold for exactly one cycle (match) or until the next change (match_count).
- Back-to-back hits on consecutive valid cycles produce match high on consecutive cycles.
- in_valid low:
  - History, fill, and count hold.
  - match deasserts on the next cycle.
  - Gaps do not break a partial match.
- reset mid-stream wins over every other input. The next cycle shows IDLE and all outputs 0, and the partial match is lost.
- cfg_load and reset in the same cycle: reset wins.
- armed rises on the cycle after a legal cfg_load. Valid bits are accepted from that cycle on.

## Test plan
- Config pattern=0b1010, pat_len=4, overlap=1. Stream 1,0,1,0,1,0 -> match pulses after bits 4 and 6; match_count=2.
- Same pattern with overlap=0. Stream 1,0,1,0,1,0,1,0 -> match after bits 4 and 8 only; match_count=2.
- pattern=0b1010, overlap=1. Stream 1,0,(in_valid=0 for 3 cycles),1,0 -> single match after the last bit; no match during the gap.
- CNT_W=2, pat_len=1, pattern=1. Feed 5 ones -> match_count=3, count_sat=1. Then clr_count with a concurrent hit -> match_count=1, count_sat=0.
- cfg_load with pat_len=0, then pat_len=MAX_LEN+1 -> cfg_err=1, armed=0. Next, cfg_load with pat_len=8 and pattern=0xA5 -> cfg_err=0, armed=1. Stream 1,0,1,0,0,1,0,1 -> one match.
- Mid-pattern after 1,0,1: assert reset for one cycle, reload the config, send 0 -> no match. Separately, after 1,0,1 issue cfg_load while presenting 0 -> no match; the history is cleared.

Source files
------------

// File: rtl/seq_det_param.sv
// Serial pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits,
// selectable overlapping/non-overlapping matching and a saturating match counter.
module seq_det_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               armed,
  output logic               cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state;
  logic [MAX_LEN-1:0] hist, pat_r, hist_next, mask;
  logic [LEN_W-1:0]   fill, len_r, fill_next;
  logic               ovl_r, len_ok, hit;

  always_comb begin
    len_ok    = (pat_len != '0) && (pat_len <= MAX_L);
    hist_next = {hist[MAX_LEN-2:0], x};
    fill_next = (fill == MAX_L) ? fill : fill + LEN_ONE;
    mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      mask[i] = (LEN_W'(i) < len_r);
    // A cfg_load cycle discards the presented bit, so it can never complete a match.
    hit = (state == RUN) && in_valid && !cfg_load && (fill_next >= len_r) &&
          ((hist_next & mask) == (pat_r & mask));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hist        <= '0;
      fill        <= '0;
      pat_r       <= '0;
      len_r       <= '0;
      ovl_r       <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
      armed       <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      match <= hit;

      case (state)
        IDLE: begin
          if (cfg_load) begin
            if (len_ok) begin
              pat_r   <= pattern;
              len_r   <= pat_len;
              ovl_r   <= overlap;
              hist    <= '0;
              fill    <= '0;
              cfg_err <= 1'b0;
              armed   <= 1'b1;
              state   <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cfg_load) begin
            if (len_ok) begin
              pat_r   <= pattern;
              len_r   <= pat_len;
              ovl_r   <= overlap;
              hist    <= '0;
              fill    <= '0;
              cfg_err <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
              armed   <= 1'b0;
              state   <= IDLE;
            end
          end else if (in_valid) begin
            hist <= hist_next;
            fill <= (hit && !ovl_r) ? '0 : fill_next;
          end
        end
        default: state <= IDLE;
      endcase

      // Clear wins over increment, but a coincident hit still counts as one.
      if (clr_count) begin
        match_count <= hit ? CNT_ONE : '0;
        count_sat   <= hit && (CNT_W == 1);
      end else if (hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_ONE;
        if (match_count + CNT_ONE == CNT_MAX)
          count_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: directed scenarios plus randomized traffic,
// all compared every cycle against a bit-queue reference model.
module tb_seq_det_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               x = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic               overlap = 1'b0;
  logic               clr_count = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;
  logic               armed;
  logic               cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  seq_det_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clr_count(clr_count),
    .match(match), .match_count(match_count), .count_sat(count_sat),
    .armed(armed), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: received bits kept in a queue, matched against the pattern MSB-first.
  bit       m_armed, m_err, m_ovl, m_match, m_sat;
  bit [7:0] m_pat;
  int       m_len, m_n, m_cnt;
  bit       q[$];

  function automatic bit tail_matches();
    for (int k = 0; k < m_len; k++)
      if (m_pat[m_len-1-k] != q[q.size()-m_len+k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    bit hit, legal;
    hit   = 1'b0;
    legal = (pat_len >= 1) && (pat_len <= MAX_LEN);
    if (reset) begin
      m_armed = 0; m_err = 0; m_ovl = 0; m_match = 0; m_sat = 0;
      m_pat = 0; m_len = 0; m_n = 0; m_cnt = 0;
      q.delete();
      return;
    end
    if (cfg_load) begin
      if (legal) begin
        m_pat = pattern; m_len = int'(pat_len); m_ovl = overlap;
        m_n = 0; q.delete(); m_err = 0; m_armed = 1;
      end else begin
        m_err = 1; m_armed = 0;
      end
    end else if (m_armed && in_valid) begin
      q.push_back(x);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      m_n++;
      hit = (m_n >= m_len) && tail_matches();
      if (hit && !m_ovl) m_n = 0;
    end
    m_match = hit;
    if (clr_count) begin
      m_cnt = hit ? 1 : 0;
      m_sat = hit && (m_cnt == CNT_MAX);
    end else if (hit && m_cnt != CNT_MAX) begin
      m_cnt++;
      if (m_cnt == CNT_MAX) m_sat = 1;
    end
  endtask

  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
    check("match", int'(match), int'(m_match));
    check("match_count", int'(match_count), m_cnt);
    check("count_sat", int'(count_sat), int'(m_sat));
    check("armed", int'(armed), int'(m_armed));
    check("cfg_err", int'(cfg_err), int'(m_err));
  endtask

  task automatic load(input logic [7:0] p, input int l, input logic o, input logic clr);
    pattern = p; pat_len = LEN_W'(l); overlap = o; cfg_load = 1'b1; clr_count = clr;
    cyc();
    cfg_load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic bits_in(input logic [7:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      x = b[i]; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_count", int'(match_count), 0);

    // Overlapping 1010 over 101010: matches after bits 4 and 6.
    load(8'b1010, 4, 1'b1, 1'b1);
    bits_in(8'b101010, 6);
    check("ovl_count", int'(match_count), 2);

    // Non-overlapping 1010 over 10101010: matches after bits 4 and 8.
    load(8'b1010, 4, 1'b0, 1'b1);
    bits_in(8'b10101010, 8);
    check("novl_count", int'(match_count), 2);

    // Gap in in_valid does not break a partial match.
    load(8'b1010, 4, 1'b1, 1'b1);
    bits_in(8'b10, 2);
    repeat (3) cyc();
    bits_in(8'b10, 2);
    check("gap_count", int'(match_count), 1);

    // Length-1 pattern, saturation, then clear with a coincident hit.
    load(8'b1, 1, 1'b0, 1'b1);
    bits_in(8'b11111, 5);
    check("sat_count", int'(match_count), 3);
    check("sat_flag", int'(count_sat), 1);
    x = 1'b1; in_valid = 1'b1; clr_count = 1'b1;
    cyc();
    in_valid = 1'b0; clr_count = 1'b0;
    check("clr_hit_count", int'(match_count), 1);
    check("clr_hit_sat", int'(count_sat), 0);

    // Illegal lengths, then full-length 0xA5.
    load(8'hA5, 0, 1'b1, 1'b0);
    check("err_len0", int'(cfg_err), 1);
    check("armed_len0", int'(armed), 0);
    load(8'hA5, MAX_LEN + 1, 1'b1, 1'b0);
    check("err_len9", int'(cfg_err), 1);
    load(8'hA5, 8, 1'b1, 1'b1);
    check("err_clear", int'(cfg_err), 0);
    check("armed_a5", int'(armed), 1);
    bits_in(8'hA5, 8);
    check("a5_count", int'(match_count), 1);

    // Reset mid-pattern loses the partial match.
    load(8'b1010, 4, 1'b1, 1'b1);
    bits_in(8'b101, 3);
    reset = 1'b1; cyc(); reset = 1'b0;
    load(8'b1010, 4, 1'b1, 1'b0);
    bits_in(8'b0, 1);
    check("rst_nomatch", int'(match), 0);

    // Reload while presenting the completing bit discards it and clears history.
    bits_in(8'b101, 3);
    x = 1'b0; in_valid = 1'b1;
    load(8'b1010, 4, 1'b1, 1'b0);
    check("reload_nomatch", int'(match), 0);
    in_valid = 1'b0;
    bits_in(8'b0, 1);
    check("reload_hist", int'(match), 0);

    // Randomized traffic; config inputs wiggle freely between loads.
    for (int i = 0; i < 3000; i++) begin
      x         = 1'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      pattern   = 8'($urandom);
      overlap   = 1'($urandom);
      pat_len   = ($urandom_range(0, 9) < 8) ? LEN_W'($urandom_range(1, 4))
                                             : LEN_W'($urandom_range(0, 9));
      cfg_load  = ($urandom_range(0, 49) == 0);
      clr_count = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      if (!armed && !cfg_load && $urandom_range(0, 3) == 0) cfg_load = 1'b1;
      cyc();
    end
    reset = 1'b0; cfg_load = 1'b0; clr_count = 1'b0; in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
